// File: rtl/lfsr_11_pkg.sv
// Shared constants, FSM state type and the single-bit divider step for the
// lfsr_11 receive-side checker.
package lfsr_11_pkg;

    localparam int POLY_W   = 86;
    localparam int WORD_W   = 15;
    localparam int LEN_W    = 16;
    localparam int MIN_BITS = 87;
    localparam int NBITS_W  = 4;

    // Feedback taps above bit 0; bit 0 always receives msb^d.
    localparam int TAP_N = 5;
    localparam int TAPS [TAP_N] = '{32, 47, 56, 65, 78};

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        RUN    = 2'd1,
        RESULT = 2'd2
    } fsm_t;

    function automatic logic [POLY_W-1:0] build_mask();
        logic [POLY_W-1:0] m;
        m    = '0;
        m[0] = 1'b1;
        for (int i = 0; i < TAP_N; i++) begin
            m[TAPS[i]] = 1'b1;
        end
        return m;
    endfunction

    localparam logic [POLY_W-1:0] POLY_MASK = build_mask();

    // One divider step: shift in d, fold the outgoing msb back onto the taps.
    function automatic logic [POLY_W-1:0] div_step(input logic [POLY_W-1:0] s,
                                                   input logic              d);
        logic msb;
        msb = s[POLY_W-1];
        return {s[POLY_W-2:0], d} ^ ({POLY_W{msb}} & POLY_MASK);
    endfunction

endpackage

// File: rtl/lfsr_11_chk_step.sv
// Combinational multi-bit divider advance: applies in_data bits 0..nbits-1
// (earliest first) to the incoming state; higher word bits are ignored.
module lfsr_11_chk_step
    import lfsr_11_pkg::*;
(
    input  logic [POLY_W-1:0]  state,
    input  logic [WORD_W-1:0]  word,
    input  logic [NBITS_W-1:0] nbits,
    output logic [POLY_W-1:0]  state_next
);

    // Unrolled chain of single-bit steps, each gated by the bit count.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path leaves it unassigned (no latch).
        state_next = state;
        for (int i = 0; i < WORD_W; i++) begin
            if (i < int'(nbits)) begin
                state_next = div_step(state_next, word[i]);
            end
        end
    end

endmodule

// File: rtl/lfsr_11_chk.sv
// lfsr_11_chk: receive-side frame checker for the 86-bit polynomial divider.
// Accepts framed 15-bit words, divides every bit, and reports syndrome, pass
// flag and saturating bit length on a valid/ready result port.
// Optional: define LFSR_11_SEED_EN to add a per-frame divider seed input.
module lfsr_11_chk
    import lfsr_11_pkg::*;
(
    input  logic               clk,
    input  logic               rst,
    input  logic [WORD_W-1:0]  in_data,
    input  logic               in_valid,
    input  logic               in_last,
    input  logic [NBITS_W-1:0] in_nbits,
`ifdef LFSR_11_SEED_EN
    input  logic [POLY_W-1:0]  seed,
`endif
    output logic               in_ready,
    output logic               res_valid,
    input  logic               res_ready,
    output logic               res_ok,
    output logic [POLY_W-1:0]  res_syndrome,
    output logic [LEN_W-1:0]   res_len,
    output logic               res_ovf
);

    fsm_t               fsm;
    logic [POLY_W-1:0]  div_q;
    logic [LEN_W-1:0]   len_q;
    logic               ovf_q;

    logic               accept;
    logic [NBITS_W-1:0] eff_nbits;
    logic [POLY_W-1:0]  seed_val;
    logic [POLY_W-1:0]  div_base;
    logic [POLY_W-1:0]  div_next;
    logic [LEN_W-1:0]   len_base;
    logic               ovf_base;
    logic [LEN_W:0]     len_sum;
    logic [LEN_W-1:0]   len_next;
    logic               ovf_next;

`ifdef LFSR_11_SEED_EN
    assign seed_val = seed;
`else
    assign seed_val = '0;
`endif

    assign accept = in_valid && in_ready;

    // Bits contributed by the current word; a last-word count of 0 means a full word.
    always_comb begin
        eff_nbits = NBITS_W'(WORD_W);
        if (in_last && (in_nbits != '0)) begin
            eff_nbits = in_nbits;
        end
    end

    // The first word of a frame starts from the seed and a zero length.
    always_comb begin
        div_base = div_q;
        len_base = len_q;
        ovf_base = ovf_q;
        if (fsm == IDLE) begin
            div_base = seed_val;
            len_base = '0;
            ovf_base = 1'b0;
        end
    end

    // Saturating length accumulation with a sticky overflow flag.
    always_comb begin
        len_sum  = {1'b0, len_base} + {{(LEN_W + 1 - NBITS_W){1'b0}}, eff_nbits};
        len_next = len_sum[LEN_W] ? '1 : len_sum[LEN_W-1:0];
        ovf_next = ovf_base | len_sum[LEN_W];
    end

    lfsr_11_chk_step u_step (
        .state      (div_base),
        .word       (in_data),
        .nbits      (eff_nbits),
        .state_next (div_next)
    );

    // Frame FSM, divider/length accumulators and registered result port.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fsm          <= IDLE;
            div_q        <= '0;
            len_q        <= '0;
            ovf_q        <= 1'b0;
            in_ready     <= 1'b1;
            res_valid    <= 1'b0;
            res_ok       <= 1'b0;
            res_syndrome <= '0;
            res_len      <= '0;
            res_ovf      <= 1'b0;
        end else begin
            // NOTE: sequential state uses non-blocking assignments so every register sees pre-edge values.
            case (fsm)
                IDLE, RUN: begin
                    if (accept) begin
                        div_q <= div_next;
                        len_q <= len_next;
                        ovf_q <= ovf_next;
                        if (in_last) begin
                            fsm          <= RESULT;
                            in_ready     <= 1'b0;
                            res_valid    <= 1'b1;
                            res_syndrome <= div_next;
                            res_len      <= len_next;
                            res_ovf      <= ovf_next;
                            res_ok       <= (div_next == '0) &&
                                            (len_next >= LEN_W'(MIN_BITS)) &&
                                            !ovf_next;
                        end else begin
                            fsm <= RUN;
                        end
                    end
                end
                RESULT: begin
                    if (res_ready) begin
                        fsm       <= IDLE;
                        in_ready  <= 1'b1;
                        res_valid <= 1'b0;
                    end
                end
                default: begin
                    fsm      <= IDLE;
                    in_ready <= 1'b1;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_lfsr_11_chk.sv
// Self-checking bench for lfsr_11_chk: table-driven frames with hand-computed
// results plus directed golden-codeword, backpressure, reset and overflow runs.
module tb_lfsr_11_chk;

    logic        clk = 1'b0;
    logic        rst;
    logic [14:0] in_data;
    logic        in_valid;
    logic        in_last;
    logic [3:0]  in_nbits;
    logic        in_ready;
    logic        res_valid;
    logic        res_ready;
    logic        res_ok;
    logic [85:0] res_syndrome;
    logic [15:0] res_len;
    logic        res_ovf;
`ifdef LFSR_11_SEED_EN
    logic [85:0] seed = '0;
`endif

    int tests_run = 0;
    int tests_failed = 0;

    always #5 clk = ~clk;

    lfsr_11_chk dut (
        .clk          (clk),
        .rst          (rst),
        .in_data      (in_data),
        .in_valid     (in_valid),
        .in_last      (in_last),
        .in_nbits     (in_nbits),
`ifdef LFSR_11_SEED_EN
        .seed         (seed),
`endif
        .in_ready     (in_ready),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_ok       (res_ok),
        .res_syndrome (res_syndrome),
        .res_len      (res_len),
        .res_ovf      (res_ovf)
    );

    typedef struct {
        string       name;
        logic [14:0] first_word;
        logic [14:0] fill_word;
        int          nwords;
        logic [3:0]  last_nbits;
        logic [85:0] exp_synd;
        logic        exp_ok;
        logic [15:0] exp_len;
    } vec_t;

    vec_t vecs [9];

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        tests_run++;
        if (act !== exp) begin
            tests_failed++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Independent bit-serial model of the divider.
    function automatic logic [85:0] model_step(input logic [85:0] s, input logic d);
        logic [85:0] n;
        logic        fb;
        int          taps [5];
        taps = '{32, 47, 56, 65, 78};
        fb   = s[85];
        n[0] = fb ^ d;
        for (int k = 1; k < 86; k++) n[k] = s[k-1];
        for (int t = 0; t < 5; t++) n[taps[t]] = n[taps[t]] ^ fb;
        return n;
    endfunction

    // Present one word and hold it until it is accepted (bounded).
    task automatic push(input logic [14:0] d, input logic last, input logic [3:0] nb);
        int n;
        n = 0;
        @(negedge clk);
        in_data  = d;
        in_valid = 1'b1;
        in_last  = last;
        in_nbits = nb;
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) check("push_timeout", 128'(in_ready), 128'(1));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Check the result that should appear right after the last word, then handshake.
    task automatic get_result(input string name, input logic [85:0] synd, input logic ok,
                              input logic [15:0] len, input logic ovf);
        int n;
        n = 0;
        @(negedge clk);
        check({name, "_latency"}, 128'(res_valid), 128'(1));
        while (!res_valid && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_syndrome"}, 128'(res_syndrome), 128'(synd));
        check({name, "_ok"}, 128'(res_ok), 128'(ok));
        check({name, "_len"}, 128'(res_len), 128'(len));
        check({name, "_ovf"}, 128'(res_ovf), 128'(ovf));
        check({name, "_in_ready_low"}, 128'(in_ready), 128'(0));
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
    endtask

    task automatic run_vec(input vec_t v);
        for (int w = 0; w < v.nwords; w++) begin
            push((w == 0) ? v.first_word : v.fill_word, (w == v.nwords - 1), v.last_nbits);
        end
        get_result(v.name, v.exp_synd, v.exp_ok, v.exp_len, 1'b0);
    endtask

    // Send a time-ordered bit vector as a frame of nbits_total bits.
    task automatic send_bits(input logic [239:0] b, input int nbits_total);
        int nw;
        int lastn;
        logic [14:0] w;
        nw    = (nbits_total + 14) / 15;
        lastn = nbits_total - 15 * (nw - 1);
        for (int i = 0; i < nw; i++) begin
            for (int j = 0; j < 15; j++) w[j] = b[i*15 + j];
            push(w, (i == nw - 1), 4'(lastn));
        end
    endtask

    initial begin
        logic [85:0]  tap_mask;
        logic [239:0] bits;
        logic [85:0]  s;
        logic [85:0]  r;
        logic [85:0]  hold_synd;

        tap_mask = 86'd1 | (86'd1 << 32) | (86'd1 << 47) | (86'd1 << 56) |
                   (86'd1 << 65) | (86'd1 << 78);

        //        name         first     fill   nw  nb     synd          ok   len
        vecs[0] = '{"zero90",   15'h0000, 15'h0, 6, 4'd0,  86'd0,        1'b1, 16'd90};
        vecs[1] = '{"onebit",   15'h0001, 15'h0, 1, 4'd1,  86'd1,        1'b0, 16'd1};
        vecs[2] = '{"impulse87",15'h0001, 15'h0, 6, 4'd12, tap_mask,     1'b0, 16'd87};
        vecs[3] = '{"zero86",   15'h0000, 15'h0, 6, 4'd11, 86'd0,        1'b0, 16'd86};
        vecs[4] = '{"zero87",   15'h0000, 15'h0, 6, 4'd12, 86'd0,        1'b1, 16'd87};
        vecs[5] = '{"impulse86",15'h0001, 15'h0, 6, 4'd11, 86'd1 << 85,  1'b0, 16'd86};
        vecs[6] = '{"zero15",   15'h0000, 15'h0, 1, 4'd0,  86'd0,        1'b0, 16'd15};
        vecs[7] = '{"masked",   15'h7ffe, 15'h0, 1, 4'd1,  86'd0,        1'b0, 16'd1};
        vecs[8] = '{"twobits",  15'h0003, 15'h0, 1, 4'd2,  86'd3,        1'b0, 16'd2};

        rst       = 1'b1;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        in_nbits  = '0;
        res_ready = 1'b0;

        // Reset values.
        #2;
        check("rst_in_ready", 128'(in_ready), 128'(1));
        check("rst_res_valid", 128'(res_valid), 128'(0));
        check("rst_res_ok", 128'(res_ok), 128'(0));
        check("rst_res_syndrome", 128'(res_syndrome), 128'(0));
        check("rst_res_len", 128'(res_len), 128'(0));
        check("rst_res_ovf", 128'(res_ovf), 128'(0));
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;

        // Table-driven frames.
        for (int i = 0; i < 9; i++) run_vec(vecs[i]);

        // Golden codeword: 150 random data bits followed by the 86 check bits, msb first.
        bits = '0;
        for (int i = 0; i < 150; i++) bits[i] = 1'($urandom_range(0, 1));
        s = '0;
        for (int i = 0; i < 150; i++) s = model_step(s, bits[i]);
        for (int i = 0; i < 86; i++) s = model_step(s, 1'b0);
        r = s;
        for (int j = 0; j < 86; j++) bits[150 + j] = r[85 - j];
        send_bits(bits, 236);
        get_result("golden", 86'd0, 1'b1, 16'd236, 1'b0);

        // Same codeword with one data bit flipped.
        bits[37] = ~bits[37];
        s = '0;
        for (int i = 0; i < 236; i++) s = model_step(s, bits[i]);
        check("flip_model_nonzero", 128'(s != '0), 128'(1));
        send_bits(bits, 236);
        get_result("flipped", s, 1'b0, 16'd236, 1'b0);

        // Backpressure: result pending while a new word waits.
        push(15'h0001, 1'b1, 4'd1);
        @(negedge clk);
        hold_synd = res_syndrome;
        in_data   = 15'h0000;
        in_valid  = 1'b1;
        in_last   = 1'b1;
        in_nbits  = 4'd5;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check("bp_in_ready", 128'(in_ready), 128'(0));
            check("bp_res_valid", 128'(res_valid), 128'(1));
            check("bp_res_len", 128'(res_len), 128'(1));
            check("bp_res_syndrome", 128'(res_syndrome), 128'(1));
        end
        res_ready = 1'b1;
        @(posedge clk);
        #1;
        res_ready = 1'b0;
        @(negedge clk);
        check("bp_release_in_ready", 128'(in_ready), 128'(1));
        check("bp_release_res_valid", 128'(res_valid), 128'(0));
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
        get_result("bp_next", 86'd0, 1'b0, 16'd5, 1'b0);

        // Reset mid-RUN discards the partial frame.
        push(15'h5555, 1'b0, 4'd0);
        push(15'h2aaa, 1'b0, 4'd0);
        push(15'h7fff, 1'b0, 4'd0);
        @(negedge clk);
        rst = 1'b1;
        #2;
        check("midrst_res_valid", 128'(res_valid), 128'(0));
        check("midrst_in_ready", 128'(in_ready), 128'(1));
        check("midrst_res_len", 128'(res_len), 128'(0));
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("midrst_no_result", 128'(res_valid), 128'(0));
        run_vec(vecs[0]);

        // Length saturation: 4370 full words = 65550 bits.
        for (int w = 0; w < 4370; w++) push(15'h0000, (w == 4369), 4'd0);
        get_result("ovf", 86'd0, 1'b0, 16'hffff, 1'b1);

        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
